// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, opcode encodings and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  // Opcodes occupy the top nibble of an instruction word.
  localparam logic [3:0] P_NOOP  = 4'h0;
  localparam logic [3:0] P_LOAD  = 4'h1;
  localparam logic [3:0] P_STORE = 4'h2;
  localparam logic [3:0] P_ADD   = 4'h3;
  localparam logic [3:0] P_SUB   = 4'h4;
  localparam logic [3:0] P_HALT  = 4'hF;

  // Full instruction word for a no-op, loaded into IR when a fetch is aborted.
  localparam logic [DATA_W-1:0] NOOP_WORD = {P_NOOP, 12'h000};

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus.
//   master (fetch unit): drives IM_ADDR, IM_RD_EN; receives IM_RDATA, IM_VALID
//   slave  (memory)    : the reverse
interface instr_fetch_unit_if import cpu_pkg::*; #(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
) ();

  logic [AW-1:0] IM_ADDR;
  logic          IM_RD_EN;
  logic [DW-1:0] IM_RDATA;
  logic          IM_VALID;

  modport master (output IM_ADDR, IM_RD_EN, input IM_RDATA, IM_VALID);
  modport slave  (input IM_ADDR, IM_RD_EN, output IM_RDATA, IM_VALID);

endinterface

// File: rtl/pc_reg.sv
// Program counter with clear-over-increment priority and modulo-2^W wrap.
//   Clock, Reset : clock, synchronous active-high reset
//   clr          : load 0 (wins over inc)
//   inc          : advance by one, wrapping silently
//   pc           : current count
module pc_reg import cpu_pkg::*; #(
  parameter int unsigned W = ADDR_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge Clock) begin
    if (Reset || clr) pc <= '0;
    else if (inc)     pc <= pc + W'(1);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches the word at PC from a
// variable-latency instruction memory on each IR_LD.
//   Clock, Reset       : clock, synchronous active-high reset
//   PC_CLR, PC_IC      : clear / increment PC (clear also aborts a fetch)
//   IR_LD              : fetch request pulse
//   IR, IR_READY       : instruction register and its fresh-word level flag
//   BUSY               : fetch in flight
//   PC                 : program counter
//   FETCH_ERR          : sticky fetch-timeout flag
//   im                 : instruction-memory read bus (master side)
// Optional feature: define FETCH_TIMEOUT_EN to abort fetches after TIMEOUT
// wait cycles with a no-op in IR and FETCH_ERR set; otherwise fetches wait
// indefinitely and FETCH_ERR is tied low.
module instr_fetch_unit import cpu_pkg::*; #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cpu_pkg::DATA_W
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = cpu_pkg::TIMEOUT
`endif
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PC_CLR,
  input  logic              PC_IC,
  input  logic              IR_LD,
  output logic [DATA_W-1:0] IR,
  output logic              IR_READY,
  output logic              BUSY,
  output logic [ADDR_W-1:0] PC,
  output logic              FETCH_ERR,
  instr_fetch_unit_if.master im
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_d;
  logic              ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
`endif

  pc_reg #(.W(ADDR_W)) u_pc (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (PC_CLR),
    .inc   (PC_IC),
    .pc    (PC)
  );

  assign im.IM_ADDR  = addr_q;
  assign im.IM_RD_EN = rd_en_q;

  // State and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      IR       <= '0;
      IR_READY <= 1'b0;
      BUSY     <= 1'b0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      FETCH_ERR <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      IR       <= ir_d;
      IR_READY <= ready_d;
      BUSY     <= (state_d == WAIT);
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      FETCH_ERR <= err_d;
`endif
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign FETCH_ERR = 1'b0;
`endif

  // Next-state and next-output logic; PC_CLR overrides everything.
  always_comb begin
    state_d = state_q;
    ir_d    = IR;
    ready_d = IR_READY;
    addr_d  = addr_q;
    rd_en_d = rd_en_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = FETCH_ERR;
`endif

    if (PC_CLR) begin
      state_d = IDLE;
      rd_en_d = 1'b0;
      ready_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (IR_LD) begin
            addr_d  = PC;
            rd_en_d = 1'b1;
            ready_d = 1'b0;
            state_d = WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        WAIT: begin
          if (im.IM_VALID) begin
            ir_d    = im.IM_RDATA;
            rd_en_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          // Abort on the TIMEOUT-th consecutive wait cycle; real data above wins.
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            ir_d    = DATA_W'(NOOP_WORD);
            rd_en_d = 1'b0;
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              PC_CLR, PC_IC, IR_LD;
  logic [DATA_W-1:0] IR;
  logic              IR_READY, BUSY, FETCH_ERR;
  logic [ADDR_W-1:0] PC;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if im_if ();

  instr_fetch_unit dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PC_CLR    (PC_CLR),
    .PC_IC     (PC_IC),
    .IR_LD     (IR_LD),
    .IR        (IR),
    .IR_READY  (IR_READY),
    .BUSY      (BUSY),
    .PC        (PC),
    .FETCH_ERR (FETCH_ERR),
    .im        (im_if.master)
  );

  always #5 Clock = ~Clock;

  // Memory model: answers after mem_wait cycles of IM_RD_EN, or never.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        mem_wait;
  logic              mem_never;
  logic              force_valid;
  logic [7:0]        wait_cnt;

  assign im_if.IM_VALID = force_valid ||
                          (im_if.IM_RD_EN && !mem_never && (wait_cnt == mem_wait));
  assign im_if.IM_RDATA = force_valid ? 16'hDEAD : mem[im_if.IM_ADDR];

  always @(posedge Clock) begin
    if (!im_if.IM_RD_EN)      wait_cnt <= 8'd0;
    else if (!im_if.IM_VALID) wait_cnt <= wait_cnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[0] = 16'h2013;
    mem[5] = 16'hA5C3;
    mem[6] = 16'h1111;
    mem_wait = 8'd0; mem_never = 1'b0; force_valid = 1'b0; wait_cnt = 8'd0;
    Reset = 1'b1; PC_CLR = 1'b0; PC_IC = 1'b0; IR_LD = 1'b0;
    tick(); tick();
    Reset = 1'b0;

    // Reset state
    check("rst_pc",    32'(PC), 32'h0);
    check("rst_ir",    32'(IR), 32'h0);
    check("rst_ready", 32'(IR_READY), 32'h0);
    check("rst_busy",  32'(BUSY), 32'h0);
    check("rst_rden",  32'(im_if.IM_RD_EN), 32'h0);
    check("rst_addr",  32'(im_if.IM_ADDR), 32'h0);
    check("rst_err",   32'(FETCH_ERR), 32'h0);

    // Zero-wait fetch of mem[0]
    IR_LD = 1'b1; tick(); IR_LD = 1'b0;
    check("z_rden",  32'(im_if.IM_RD_EN), 32'h1);
    check("z_busy",  32'(BUSY), 32'h1);
    check("z_addr",  32'(im_if.IM_ADDR), 32'h0);
    tick();
    check("z_ir",    32'(IR), 32'h2013);
    check("z_ready", 32'(IR_READY), 32'h1);
    check("z_rden0", 32'(im_if.IM_RD_EN), 32'h0);
    check("z_busy0", 32'(BUSY), 32'h0);
    check("z_pc",    32'(PC), 32'h0);

    // PC wrap 0xFF -> 0x00, other outputs undisturbed
    PC_IC = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    PC_IC = 1'b0;
    check("w_pcff", 32'(PC), 32'hFF);
    PC_IC = 1'b1; tick(); PC_IC = 1'b0;
    check("w_pc00",  32'(PC), 32'h00);
    check("w_ir",    32'(IR), 32'h2013);
    check("w_ready", 32'(IR_READY), 32'h1);
    check("w_busy",  32'(BUSY), 32'h0);
    check("w_rden",  32'(im_if.IM_RD_EN), 32'h0);

    // Wait-3 fetch with PC_IC mid-WAIT
    PC_IC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    PC_IC = 1'b0;
    check("l_pc5", 32'(PC), 32'h5);
    mem_wait = 8'd3;
    IR_LD = 1'b1; tick(); IR_LD = 1'b0;          // n+1
    check("l_rden",   32'(im_if.IM_RD_EN), 32'h1);
    check("l_ready0", 32'(IR_READY), 32'h0);
    PC_IC = 1'b1; tick(); PC_IC = 1'b0;          // n+2
    check("l_pc6",  32'(PC), 32'h6);
    check("l_addr", 32'(im_if.IM_ADDR), 32'h5);
    check("l_busy", 32'(BUSY), 32'h1);
    IR_LD = 1'b1; tick(); IR_LD = 1'b0;          // n+3, ignored request
    tick();                                      // n+4
    check("l_notyet", 32'(IR_READY), 32'h0);
    tick();                                      // n+5
    check("l_ir",    32'(IR), 32'hA5C3);
    check("l_ready", 32'(IR_READY), 32'h1);
    check("l_pc",    32'(PC), 32'h6);
    tick();
    check("l_noq", 32'(BUSY), 32'h0);

    // PC_CLR during WAIT, late data discarded
    mem_wait = 8'd2;
    IR_LD = 1'b1; tick(); IR_LD = 1'b0;
    check("c_busy1", 32'(BUSY), 32'h1);
    PC_CLR = 1'b1; tick(); PC_CLR = 1'b0;
    check("c_rden",  32'(im_if.IM_RD_EN), 32'h0);
    check("c_busy",  32'(BUSY), 32'h0);
    check("c_ready", 32'(IR_READY), 32'h0);
    check("c_pc",    32'(PC), 32'h0);
    check("c_ir",    32'(IR), 32'hA5C3);
    force_valid = 1'b1; tick(); tick(); force_valid = 1'b0;
    check("c_late_ir",    32'(IR), 32'hA5C3);
    check("c_late_ready", 32'(IR_READY), 32'h0);

    // PC_CLR and IR_LD together: no request
    PC_IC = 1'b1; tick(); tick(); tick(); PC_IC = 1'b0;
    check("b_pc3", 32'(PC), 32'h3);
    PC_CLR = 1'b1; IR_LD = 1'b1; tick(); PC_CLR = 1'b0; IR_LD = 1'b0;
    check("b_rden",  32'(im_if.IM_RD_EN), 32'h0);
    check("b_pc",    32'(PC), 32'h0);
    tick();
    check("b_rden2", 32'(im_if.IM_RD_EN), 32'h0);
    check("b_busy",  32'(BUSY), 32'h0);

    // Memory that never answers
    mem_never = 1'b1;
    IR_LD = 1'b1; tick(); IR_LD = 1'b0;          // WAIT cycle 1
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();          // WAIT cycle 15
    check("t_busy15", 32'(BUSY), 32'h1);
    tick();
    check("t_ir",    32'(IR), 32'h0000);
    check("t_ready", 32'(IR_READY), 32'h1);
    check("t_err",   32'(FETCH_ERR), 32'h1);
    check("t_busy",  32'(BUSY), 32'h0);
    check("t_rden",  32'(im_if.IM_RD_EN), 32'h0);
    tick();
    check("t_sticky", 32'(FETCH_ERR), 32'h1);
    PC_CLR = 1'b1; tick(); PC_CLR = 1'b0;
    check("t_errclr", 32'(FETCH_ERR), 32'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    check("n_busy", 32'(BUSY), 32'h1);
    check("n_rden", 32'(im_if.IM_RD_EN), 32'h1);
    check("n_err",  32'(FETCH_ERR), 32'h0);
    PC_CLR = 1'b1; tick(); PC_CLR = 1'b0;
    check("n_busy0", 32'(BUSY), 32'h0);
`endif
    mem_never = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
